// File: rtl/rr_arbiter_8_if.sv
// Request/grant handshake bundle between requesters, the round-robin arbiter
// and the downstream 3-to-8 decoder consumer.
interface rr_arbiter_8_if;
    logic [7:0] req;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       grant_ready;

    modport master (input req, input grant_ready, output grant_valid, output grant_idx);
    modport slave  (output req, output grant_ready, input grant_valid, input grant_idx);
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered binary grant index held
// under valid/ready backpressure until accepted.
module rr_arbiter_8 #(
    parameter logic [2:0] START_PTR = 3'd0
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_8_if.master bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_reg, state_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [2:0] idx_reg, idx_next;
    logic [2:0] base;
    logic [2:0] pick_off;
    logic [2:0] pick_idx;
    logic [7:0] req_rot;
    logic       any_req;

    // In GRANT the search starts one past the current winner, which is also
    // the pointer value an acceptance would install this cycle.
    assign base    = (state_reg == GRANT) ? idx_reg + 3'd1 : ptr_reg;
    assign any_req = |bus.req;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            logic [2:0] src;
            assign src         = base + 3'(gi);
            assign req_rot[gi] = bus.req[src];
        end
    endgenerate

    always_comb begin
        pick_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) pick_off = 3'(i);
        end
    end

    assign pick_idx = base + pick_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= START_PTR;
            idx_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    idx_next   = pick_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // Without acceptance the grant is held; request changes are ignored.
                if (bus.grant_ready) begin
                    ptr_next = idx_reg + 3'd1;
                    if (any_req) idx_next = pick_idx;
                    else         state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.grant_valid = (state_reg == GRANT);
        bus.grant_idx   = idx_reg;
    end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Randomized and directed check of rr_arbiter_8 against a circular-search
// reference model of the round-robin rules.
module tb_rr_arbiter_8;
    localparam int START = 0;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    // reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(.START_PTR(3'(START))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare just after.
    task automatic step(input logic r, input logic [7:0] rq, input logic rd, input string tag);
        rst             = r;
        bus.req         = rq;
        bus.grant_ready = rd;
        @(posedge clk);
        if (r) begin
            m_valid = 0;
            m_idx   = 0;
            m_ptr   = START;
        end else if (!m_valid) begin
            if (rq != 8'h00) begin
                m_idx   = pick(rq, m_ptr);
                m_valid = 1;
            end
        end else if (rd) begin
            m_ptr = (m_idx + 1) % 8;
            if (rq != 8'h00) m_idx = pick(rq, m_ptr);
            else             m_valid = 0;
        end
        #1;
        check_val({tag, ".valid"}, int'(bus.grant_valid), int'(m_valid));
        check_val({tag, ".idx"}, int'(bus.grant_idx), m_idx);
        $display("%s rst=%b req=%02h rdy=%b -> valid=%b idx=%0d", tag, r, rq, rd,
                 bus.grant_valid, bus.grant_idx);
    endtask

    task automatic do_reset();
        step(1'b1, 8'hFF, 1'b0, "rst");
        step(1'b1, 8'hFF, 1'b0, "rst");
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        m_valid         = 0;
        m_idx           = 0;
        m_ptr           = START;
        rst             = 1'b1;
        bus.req         = 8'h00;
        bus.grant_ready = 1'b0;

        // reset values with all requests active
        do_reset();
        check_val("reset_valid", int'(bus.grant_valid), 0);
        check_val("reset_idx", int'(bus.grant_idx), 0);

        // full rotation with ready tied high
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'hFF, 1'b1, "rot");
            check_val("rot_seq", int'(bus.grant_idx), (START + i) % 8);
            check_val("rot_valid", int'(bus.grant_valid), 1);
        end

        // hold under backpressure, granted bit drops
        do_reset();
        step(1'b0, 8'h24, 1'b0, "hold");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h20, 1'b0, "hold");
            check_val("hold_idx", int'(bus.grant_idx), 2);
        end
        step(1'b0, 8'h20, 1'b1, "hold_acc");
        check_val("hold_next", int'(bus.grant_idx), 5);

        // wrap-around past 7
        do_reset();
        step(1'b0, 8'h40, 1'b0, "wrap");
        check_val("wrap_first", int'(bus.grant_idx), 6);
        step(1'b0, 8'h41, 1'b1, "wrap");
        check_val("wrap_zero", int'(bus.grant_idx), 0);
        step(1'b0, 8'h41, 1'b1, "wrap");
        check_val("wrap_six", int'(bus.grant_idx), 6);

        // sole requester repeats, then idle return
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h08, 1'b1, "sole");
            check_val("sole_idx", int'(bus.grant_idx), 3);
        end
        step(1'b0, 8'h00, 1'b1, "sole_drop");
        check_val("sole_idle", int'(bus.grant_valid), 0);
        step(1'b0, 8'h00, 1'b1, "idle_rdy");
        check_val("idle_stays", int'(bus.grant_valid), 0);

        // reset during a held grant
        do_reset();
        step(1'b0, 8'h10, 1'b0, "mid");
        step(1'b0, 8'h10, 1'b0, "mid");
        check_val("mid_idx", int'(bus.grant_idx), 4);
        step(1'b1, 8'hFF, 1'b0, "mid_rst");
        check_val("mid_rst_valid", int'(bus.grant_valid), 0);
        step(1'b0, 8'hFF, 1'b0, "mid_after");
        check_val("mid_after_idx", int'(bus.grant_idx), START);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] rq;
            logic       rd;
            logic       r;
            rq = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rq = rq & 8'($urandom);
            if ($urandom_range(0, 9) == 0) rq = 8'h00;
            rd = ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 49) == 0);
            step(r, rq, rd, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
